// File: rtl/sub_bytes_seq.sv
// Byte-serial SubBytes/InvSubBytes sequencer: feeds a shared registered S-box
// one byte per cycle and reassembles its results into a NUM_BYTES-wide word.
module sub_bytes_seq #(
    parameter int unsigned NUM_BYTES = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   enc_dec,
    input  logic [8*NUM_BYTES-1:0] data_in,
    output logic [7:0]             sbox_in,
    output logic                   sbox_enc_dec,
    input  logic [7:0]             sbox_out_enc,
    input  logic [7:0]             sbox_out_dec,
    output logic [8*NUM_BYTES-1:0] data_out,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned CNT_W = $clog2(NUM_BYTES + 1);
    localparam int unsigned W     = 8 * NUM_BYTES;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] idx;
    logic [W-1:0]     src;
    logic [W-1:0]     coll;
    logic [W-1:0]     coll_nxt;
    logic             mode;
    logic [7:0]       res_byte;
    logic             last_feed;
    logic             collect;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_feed) state_nxt = DRAIN;
            DRAIN:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy         = (state != IDLE);
    assign done         = (state == DONE);
    assign sbox_enc_dec = mode;
    assign last_feed    = (idx == CNT_W'(NUM_BYTES - 1));
    assign res_byte     = mode ? sbox_out_enc : sbox_out_dec;

    // The S-box result seen in a cycle belongs to the byte fed one cycle
    // earlier, so index idx collects byte idx-1 (DRAIN has idx == NUM_BYTES).
    assign collect = ((state == RUN) && (idx != '0)) || (state == DRAIN);

    always_comb begin
        sbox_in = '0;
        if (state == RUN) begin
            for (int unsigned i = 0; i < NUM_BYTES; i++) begin
                if (idx == CNT_W'(i)) sbox_in = src[W-1-8*i -: 8];
            end
        end
    end

    always_comb begin
        coll_nxt = coll;
        if (collect) begin
            for (int unsigned i = 0; i < NUM_BYTES; i++) begin
                if (idx == CNT_W'(i + 1)) coll_nxt[W-1-8*i -: 8] = res_byte;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx      <= '0;
            src      <= '0;
            mode     <= 1'b0;
            coll     <= '0;
            data_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        src  <= data_in;
                        mode <= enc_dec;
                        idx  <= '0;
                    end
                end
                RUN:     idx <= idx + CNT_W'(1);
                default: ;
            endcase
            coll <= coll_nxt;
            if (state == DRAIN) data_out <= coll_nxt;
        end
    end

endmodule
